// File: rtl/sw_demux_reg.sv
// sw_demux_reg: registered one-hot switch demultiplexer.
// Routes a W-bit word to one of CH channel registers.
// Also produces per-channel update pulses, the index of the last written
// channel and a saturating illegal-address counter.
// Optional build macro: SW_DEMUX_PRIORITY_EN. When it is defined, a multi-hot
// address goes to the lowest-numbered selected channel instead of channel 0.
module sw_demux_reg #(
  parameter int CH   = 5,
  parameter int W    = 4,
  parameter int ERRW = 8,
  parameter int SELW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-2:0]     adress,
  input  logic [W-1:0]      in,
  input  logic              wr_en,
  input  logic              clr,
  output logic [CH*W-1:0]   out_bus,
  output logic [CH-1:0]     upd,
  output logic [SELW-1:0]   sel_idx,
  output logic [ERRW-1:0]   err_cnt
);

  logic            w_zero;   // no address bit set
  logic            w_multi;  // two or more address bits set
  logic [SELW-1:0] w_low;    // channel of the lowest set address bit
  logic [SELW-1:0] w_tgt;    // channel that a write in this cycle lands on
  logic            w_accept; // a write is accepted at the next edge

  logic [SELW-1:0] r_sel;
  logic [ERRW-1:0] r_err;

  // Classify the address and locate its lowest set bit.
  always_comb begin
    w_zero  = (adress == '0);
    w_multi = !w_zero && ((adress & (adress - 1'b1)) != '0);
    w_low   = '0;
    for (int k = CH - 2; k >= 0; k--) begin
      if (adress[k]) begin
        w_low = SELW'(k + 1);
      end
    end
  end

  // Select the target channel for the current write.
`ifdef SW_DEMUX_PRIORITY_EN
  always_comb begin
    w_tgt = w_zero ? '0 : w_low;
  end
`else
  always_comb begin
    w_tgt = (w_zero || w_multi) ? '0 : w_low;
  end
`endif

  // Clear has priority over a write in the same cycle.
  assign w_accept = wr_en && !clr;

  // Per-channel data register and update pulse.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] r_chan;
      logic         r_upd;
      logic         w_hit;

      assign w_hit = w_accept && (w_tgt == SELW'(gi));

      // Load on a hit, clear on clr, otherwise hold; pulse upd after a load.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_chan <= '0;
          r_upd  <= 1'b0;
        end else if (clr) begin
          r_chan <= '0;
          r_upd  <= 1'b0;
        end else begin
          r_upd <= w_hit;
          if (w_hit) begin
            r_chan <= in;
          end
        end
      end

      assign out_bus[gi*W +: W] = r_chan;
      assign upd[gi]            = r_upd;
    end
  endgenerate

  // Track the last written channel and count multi-hot writes, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
      r_err <= '0;
    end else if (w_accept) begin
      r_sel <= w_tgt;
      if (w_multi && (r_err != {ERRW{1'b1}})) begin
        r_err <= r_err + ERRW'(1);
      end
    end
  end

  assign sel_idx = r_sel;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_sw_demux_reg.sv
// Directed testbench for sw_demux_reg with default parameters.
// Expected values are written by hand for both build variants.
module tb_sw_demux_reg;

  logic        clk;
  logic        rst;
  logic [3:0]  adress;
  logic [3:0]  din;
  logic        wr_en;
  logic        clr;
  logic [19:0] out_bus;
  logic [4:0]  upd;
  logic [2:0]  sel_idx;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sw_demux_reg #(.CH(5), .W(4), .ERRW(8), .SELW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .adress  (adress),
    .in      (din),
    .wr_en   (wr_en),
    .clr     (clr),
    .out_bus (out_bus),
    .upd     (upd),
    .sel_idx (sel_idx),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic c, input logic [3:0] a, input logic [3:0] d);
    wr_en  = w;
    clr    = c;
    adress = a;
    din    = d;
  endtask

  logic [19:0] exp_multi_out;
  logic [4:0]  exp_multi_upd;
  logic [2:0]  exp_multi_sel;
  logic [19:0] exp_zero_out;
  logic [19:0] exp_ch4_out;
  logic [19:0] exp_sat_out;
  logic [4:0]  exp_sat_upd;
  logic [19:0] hold_out;
  logic [3:0]  a_tog;

  initial begin
`ifdef SW_DEMUX_PRIORITY_EN
    exp_multi_out = 20'h09500;
    exp_multi_upd = 5'b00100;
    exp_multi_sel = 3'd2;
    exp_zero_out  = 20'h09507;
    exp_ch4_out   = 20'hA9507;
    exp_sat_out   = 20'h005E0;
    exp_sat_upd   = 5'b00010;
`else
    exp_multi_out = 20'h09005;
    exp_multi_upd = 5'b00001;
    exp_multi_sel = 3'd0;
    exp_zero_out  = 20'h09007;
    exp_ch4_out   = 20'hA9007;
    exp_sat_out   = 20'h0000E;
    exp_sat_upd   = 5'b00001;
`endif

    // Reset for two cycles, with a write pending that must be ignored.
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0100, 4'hF);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    step();
    check("rst_out", 32'(out_bus), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_sel", 32'(sel_idx), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);

    // One-hot write to channel 3.
    drive(1'b1, 1'b0, 4'b0100, 4'h9);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("oh_out", 32'(out_bus), 32'h09000);
    check("oh_upd", 32'(upd), 32'b01000);
    check("oh_sel", 32'(sel_idx), 32'd3);
    step();
    check("oh_upd_drop", 32'(upd), 32'h0);
    check("oh_hold", 32'(out_bus), 32'h09000);

    // Multi-hot write.
    drive(1'b1, 1'b0, 4'b0110, 4'h5);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("mh_out", 32'(out_bus), 32'(exp_multi_out));
    check("mh_upd", 32'(upd), 32'(exp_multi_upd));
    check("mh_sel", 32'(sel_idx), 32'(exp_multi_sel));
    check("mh_err", 32'(err_cnt), 32'd1);

    // Zero address routes to channel 0.
    drive(1'b1, 1'b0, 4'b0000, 4'h7);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("z_out", 32'(out_bus), 32'(exp_zero_out));
    check("z_upd", 32'(upd), 32'b00001);
    check("z_sel", 32'(sel_idx), 32'd0);
    check("z_err", 32'(err_cnt), 32'd1);

    // wr_en low while the address toggles: nothing changes.
    hold_out = out_bus;
    for (int i = 0; i < 8; i++) begin
      a_tog = 4'b0001 << (i % 4);
      drive(1'b0, 1'b0, a_tog, 4'hC);
      step();
      check($sformatf("idle_out%0d", i), 32'(out_bus), 32'(hold_out));
      check($sformatf("idle_upd%0d", i), 32'(upd), 32'h0);
    end
    check("idle_sel", 32'(sel_idx), 32'd0);

    // Load channel 4.
    drive(1'b1, 1'b0, 4'b1000, 4'hA);
    step();
    check("c4_out", 32'(out_bus), 32'(exp_ch4_out));
    check("c4_upd", 32'(upd), 32'b10000);
    check("c4_sel", 32'(sel_idx), 32'd4);

    // Clear and write together: the clear wins.
    drive(1'b1, 1'b1, 4'b1000, 4'h3);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("clr_out", 32'(out_bus), 32'h0);
    check("clr_upd", 32'(upd), 32'h0);
    check("clr_sel", 32'(sel_idx), 32'd4);
    check("clr_err", 32'(err_cnt), 32'd1);

    // Drive err_cnt up to saturation with 254 multi-hot writes.
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 1'b0, 4'b0110, 4'h5);
      step();
    end
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    step();
    check("sat_reach", 32'(err_cnt), 32'd255);

    // One more multi-hot write: counter must not wrap.
    drive(1'b1, 1'b0, 4'b1001, 4'hE);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("sat_hold", 32'(err_cnt), 32'd255);
    check("sat_out", 32'(out_bus), 32'(exp_sat_out));
    check("sat_upd", 32'(upd), 32'(exp_sat_upd));

    // Reset mid-stream with a write in the same cycle.
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0100, 4'hF);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("mrst_out", 32'(out_bus), 32'h0);
    check("mrst_upd", 32'(upd), 32'h0);
    check("mrst_sel", 32'(sel_idx), 32'h0);
    check("mrst_err", 32'(err_cnt), 32'h0);

    // Back-to-back writes to channel 1 keep upd[1] high.
    drive(1'b1, 1'b0, 4'b0001, 4'h1);
    step();
    check("b2b_upd0", 32'(upd), 32'b00010);
    check("b2b_out0", 32'(out_bus), 32'h00010);
    drive(1'b1, 1'b0, 4'b0001, 4'h2);
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'h0);
    check("b2b_upd1", 32'(upd), 32'b00010);
    check("b2b_out1", 32'(out_bus), 32'h00020);
    check("b2b_sel", 32'(sel_idx), 32'd1);
    step();
    check("b2b_upd2", 32'(upd), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
